// File: rtl/trace_uart_if.sv
// Trace capture and serial-output signal bundle for trace_uart.
interface trace_uart_if;
    logic [10:0] trace;
    logic        enable;
    logic        trace_tx;
    logic        overflow;
    logic        busy;

    modport master (
        output trace,
        output enable,
        input  trace_tx,
        input  overflow,
        input  busy
    );

    modport slave (
        input  trace,
        input  enable,
        output trace_tx,
        output overflow,
        output busy
    );
endinterface

// File: rtl/trace_uart.sv
// Captures the CPU address on each phi2 falling edge and prints it as "%04h" lines on an 8N1 UART.
// Define TRACE_UART_CRLF_EN to end each line with CR LF instead of LF only.
module trace_uart #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned FIFO_AW  = 4
) (
    input logic        clk50,
    input logic        reset,
    trace_uart_if.slave bus
);
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);
    // Stop state is one cycle short: the IDLE accept cycle completes the stop bit.
    localparam logic [15:0] StopLast = 16'(BAUD_DIV - 2);
`ifdef TRACE_UART_CRLF_EN
    localparam logic CrlfEn = 1'b1;
`else
    localparam logic CrlfEn = 1'b0;
`endif

    typedef enum logic [1:0] {FmtIdle, FmtDigit, FmtEol, FmtWait} fmt_state_e;
    typedef enum logic [1:0] {UartIdle, UartStart, UartData, UartStop} uart_state_e;

    logic [10:0]        sync1_q, sync2_q;
    logic               phi2_prev_q;
    logic [9:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               push, push_ok, pop, fifo_empty, fifo_full;

    fmt_state_e         fmt_q, fmt_d;
    logic [1:0]         idx_q, idx_d;
    logic [9:0]         word_q, word_d;
    logic               lf_q, lf_d;
    logic [15:0]        word16;
    logic [3:0]         nib;
    logic               tx_valid;
    logic [7:0]         tx_byte;

    uart_state_e        uart_q, uart_d;
    logic [15:0]        baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               uart_ready;

    // Capture path and FIFO control
    assign push       = phi2_prev_q & ~sync2_q[10] & bus.enable;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = count_q[FIFO_AW];
    assign push_ok    = push & (~fifo_full | pop);
    assign uart_ready = (uart_q == UartIdle);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push & ~push_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (push_ok) mem_q[wr_ptr_q] <= sync2_q[9:0];
    end

    // Formatter: four hex digits, then the line end
    assign word16 = {6'b111111, word_q};

    always_comb begin
        unique case (idx_q)
            2'd3: nib = word16[15:12];
            2'd2: nib = word16[11:8];
            2'd1: nib = word16[7:4];
            2'd0: nib = word16[3:0];
        endcase
    end

    always_comb begin
        fmt_d    = fmt_q;
        idx_d    = idx_q;
        word_d   = word_q;
        lf_d     = lf_q;
        pop      = 1'b0;
        tx_valid = 1'b0;
        tx_byte  = 8'h0A;
        unique case (fmt_q)
            FmtIdle: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    word_d = mem_q[rd_ptr_q];
                    idx_d  = 2'd3;
                    fmt_d  = FmtDigit;
                end
            end
            FmtDigit: begin
                tx_valid = 1'b1;
                tx_byte  = (nib < 4'd10) ? {4'h3, nib} : (8'h57 + {4'h0, nib});
                if (uart_ready) begin
                    idx_d = idx_q - 2'd1;
                    if (idx_q == 2'd0) begin
                        fmt_d = FmtEol;
                        lf_d  = ~CrlfEn;
                    end
                end
            end
            FmtEol: begin
                tx_valid = 1'b1;
                tx_byte  = lf_q ? 8'h0A : 8'h0D;
                if (uart_ready) begin
                    if (lf_q) fmt_d = FmtWait;
                    else      lf_d  = 1'b1;
                end
            end
            FmtWait: begin
                // Hold busy until the final stop bit has left the UART
                if (uart_ready) fmt_d = FmtIdle;
            end
        endcase
    end

    // UART transmitter
    always_comb begin
        uart_d     = uart_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        unique case (uart_q)
            UartIdle: begin
                baud_cnt_d = '0;
                if (tx_valid) begin
                    shift_d = tx_byte;
                    uart_d  = UartStart;
                end
            end
            UartStart: begin
                if (baud_cnt_q == BaudLast) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    uart_d     = UartData;
                end
            end
            UartData: begin
                if (baud_cnt_q == BaudLast) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) uart_d = UartStop;
                end
            end
            UartStop: begin
                if (baud_cnt_q == StopLast) begin
                    baud_cnt_d = '0;
                    uart_d     = UartIdle;
                end
            end
        endcase
        unique case (uart_q)
            UartStart: tx_d = 1'b0;
            UartData:  tx_d = shift_q[0];
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            phi2_prev_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            fmt_q       <= FmtIdle;
            idx_q       <= '0;
            word_q      <= '0;
            lf_q        <= 1'b0;
            uart_q      <= UartIdle;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
        end else begin
            sync1_q     <= bus.trace;
            sync2_q     <= sync1_q;
            phi2_prev_q <= sync2_q[10];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            fmt_q       <= fmt_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            lf_q        <= lf_d;
            uart_q      <= uart_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
        end
    end

    assign bus.trace_tx = tx_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = ~fifo_empty | (fmt_q != FmtIdle);
endmodule

// File: tb/tb_trace_uart.sv
// Bench for trace_uart: fast instance (BAUD_DIV=8, FIFO_AW=2) plus a default-parameter instance.
module tb_trace_uart;
`ifdef TRACE_UART_CRLF_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int BA = 8;
    localparam int BB = 434;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] hex;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_pass, n_checks, frame_err;
    vec_t vec [6];

    trace_uart_if bus_a ();
    trace_uart_if bus_b ();

    trace_uart #(.BAUD_DIV(BA), .FIFO_AW(2)) dut_a (.clk50(clk), .reset(rst_a), .bus(bus_a));
    trace_uart dut_b (.clk50(clk), .reset(rst_b), .bus(bus_b));

    always #5 clk = ~clk;

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 1) ? bus_b.trace_tx : bus_a.trace_tx;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? bus_b.busy : bus_a.busy;
    endfunction

    function automatic logic [47:0] exp_line(input logic [31:0] hex);
`ifdef TRACE_UART_CRLF_EN
        return {hex, 16'h0D0A};
`else
        return {8'h00, hex, 8'h0A};
`endif
    endfunction

    task automatic drive(input int sel, input logic [10:0] v);
        if (sel == 1) bus_b.trace = v;
        else          bus_a.trace = v;
    endtask

    task automatic pulse(input int sel, input logic [9:0] a);
        @(posedge clk); #1; drive(sel, {1'b1, a});
        repeat (3) @(posedge clk); #1; drive(sel, {1'b0, a});
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic rx_byte(input int sel, input int baud, output logic [7:0] b);
        int n = 0;
        b = 8'hEE;
        @(negedge clk);
        while (get_tx(sel) !== 1'b0 && n < 3 * baud + 20) begin
            @(negedge clk);
            n++;
        end
        if (get_tx(sel) !== 1'b0) begin
            frame_err++;
            return;
        end
        repeat (baud / 2) @(negedge clk);
        if (get_tx(sel) !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
            repeat (baud) @(negedge clk);
            b[i] = get_tx(sel);
        end
        repeat (baud) @(negedge clk);
        if (get_tx(sel) !== 1'b1) frame_err++;
    endtask

    task automatic rx_line(input int sel, input int baud, output logic [47:0] got);
        logic [7:0] b;
        got = '0;
        for (int i = 0; i < NB; i++) begin
            rx_byte(sel, baud, b);
            got = {got[39:0], b};
        end
    endtask

    task automatic wait_idle(input int sel, input int baud, input string name);
        int n = 0;
        while (get_busy(sel) !== 1'b0 && n < 4 * baud) begin
            @(negedge clk);
            n++;
        end
        check(name, {62'd0, get_busy(sel), get_tx(sel)}, 64'd1);
    endtask

    task automatic seq_a();
        logic [47:0] got;
        logic [31:0] got4;
        logic [7:0]  b;
        int          seen, n;
        for (int i = 0; i < 6; i++) begin
            pulse(0, vec[i].addr);
            rx_line(0, BA, got);
            check($sformatf("line addr %0h", vec[i].addr), got, exp_line(vec[i].hex));
            wait_idle(0, BA, $sformatf("idle after addr %0h", vec[i].addr));
        end

        // Captures with enable low must not reach the FIFO
        bus_a.enable = 1'b0;
        seen = 0;
        fork
            for (int i = 0; i < 10; i++) pulse(0, 10'(i * 37));
            repeat (80) begin
                @(negedge clk);
                if (bus_a.busy !== 1'b0 || bus_a.trace_tx !== 1'b1) seen++;
            end
        join
        check("enable gating activity", 64'(seen), 64'd0);
        bus_a.enable = 1'b1;

        // Overflow: one line in flight, then six fast captures into a 4-deep FIFO
        got4 = '0;
        fork
            begin
                pulse(0, 10'h3FF);
                for (int i = 0; i < 6; i++) pulse(0, 10'(i));
            end
            for (int i = 0; i < 4; i++) begin
                rx_byte(0, BA, b);
                got4 = {got4[23:0], b};
            end
        join
        check("overflow set", {63'd0, bus_a.overflow}, 64'd1);
        got = {16'h0, got4};
        for (int i = 4; i < NB; i++) begin
            rx_byte(0, BA, b);
            got = {got[39:0], b};
        end
        check("overflow first line", got, exp_line("ffff"));
        for (int i = 0; i < 4; i++) begin
            rx_line(0, BA, got);
            check($sformatf("overflow line %0d", i), got,
                  exp_line({"fc0", 8'h30 + 8'(i)}));
        end
        wait_idle(0, BA, "overflow no extra line");
        check("overflow sticky", {63'd0, bus_a.overflow}, 64'd1);

        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("overflow cleared by reset", {63'd0, bus_a.overflow}, 64'd0);

        // Collision: full FIFO, capture lands on the pop edge after the LF stop bit
        got4 = '0;
        fork
            begin
                pulse(0, 10'h3FF);
                for (int i = 0; i < 4; i++) pulse(0, 10'h010 + 10'(i));
            end
            for (int i = 0; i < 4; i++) begin
                rx_byte(0, BA, b);
                got4 = {got4[23:0], b};
            end
        join
        check("collision first digits", 64'(got4), 64'("ffff"));
`ifdef TRACE_UART_CRLF_EN
        rx_byte(0, BA, b);
        check("collision CR", 64'(b), 64'h0D);
`endif
        fork
            begin
                rx_byte(0, BA, b);
                check("collision LF", 64'(b), 64'h0A);
            end
            begin
                bus_a.trace = {1'b1, 10'h014};
                n = 0;
                @(negedge clk);
                while (bus_a.trace_tx !== 1'b0 && n < 3 * BA + 20) begin
                    @(negedge clk);
                    n++;
                end
                repeat (10 * BA - 3) @(posedge clk);
                #1;
                bus_a.trace = {1'b0, 10'h014};
            end
        join
        for (int i = 0; i < 5; i++) begin
            rx_line(0, BA, got);
            check($sformatf("collision line %0d", i), got,
                  exp_line({"fc1", 8'h30 + 8'(i)}));
        end
        check("collision overflow clear", {63'd0, bus_a.overflow}, 64'd0);
        wait_idle(0, BA, "collision drained");

        // Reset asserted while a data bit is on the line
        pulse(0, 10'h000);
        n = 0;
        @(negedge clk);
        while (bus_a.trace_tx !== 1'b0 && n < 3 * BA + 20) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check("tx low in bit0", {63'd0, bus_a.trace_tx}, 64'd0);
        #1 rst_a = 1'b1;
        #1 check("async reset outputs", {61'd0, bus_a.trace_tx, bus_a.busy, bus_a.overflow},
                 64'b100);
        @(negedge clk);
        rst_a = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus_a.busy !== 1'b0 || bus_a.trace_tx !== 1'b1) seen++;
        end
        check("quiet after reset", 64'(seen), 64'd0);
        pulse(0, 10'h123);
        rx_line(0, BA, got);
        check("line after reset", got, exp_line("fd23"));
        wait_idle(0, BA, "idle after reset line");
    endtask

    task automatic seq_b();
        logic [47:0] got;
        logic [7:0]  b;
        int          n, low;
        pulse(1, 10'h268);
        n = 0;
        @(negedge clk);
        while (bus_b.trace_tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        // 'f' = 0x66 has bit0 = 0, so the low run is start bit plus bit0
        low = 0;
        while (bus_b.trace_tx === 1'b0 && low < 2000) begin
            low++;
            @(negedge clk);
        end
        check("default start+bit0 low cycles", 64'(low), 64'(2 * BB));
        b = 8'h00;
        repeat (BB / 2) @(negedge clk);
        b[1] = bus_b.trace_tx;
        for (int i = 2; i < 8; i++) begin
            repeat (BB) @(negedge clk);
            b[i] = bus_b.trace_tx;
        end
        repeat (BB) @(negedge clk);
        if (bus_b.trace_tx !== 1'b1) frame_err++;
        got = {40'h0, b};
        for (int i = 1; i < NB; i++) begin
            rx_byte(1, BB, b);
            got = {got[39:0], b};
        end
        check("default line fe68", got, exp_line("fe68"));
        check("default busy in LF stop", {63'd0, bus_b.busy}, 64'd1);
        wait_idle(1, BB, "default idle after line");
    endtask

    initial begin
        n_pass = 0;
        n_checks = 0;
        frame_err = 0;
        vec[0].addr = 10'h268; vec[0].hex = "fe68";
        vec[1].addr = 10'h3FF; vec[1].hex = "ffff";
        vec[2].addr = 10'h000; vec[2].hex = "fc00";
        vec[3].addr = 10'h123; vec[3].hex = "fd23";
        vec[4].addr = 10'h0AB; vec[4].hex = "fcab";
        vec[5].addr = 10'h1C9; vec[5].hex = "fdc9";
        bus_a.trace = '0;
        bus_a.enable = 1'b1;
        bus_b.trace = '0;
        bus_b.enable = 1'b1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset a tx/busy/ovf", {61'd0, bus_a.trace_tx, bus_a.busy, bus_a.overflow}, 64'b100);
        check("reset b tx/busy/ovf", {61'd0, bus_b.trace_tx, bus_b.busy, bus_b.overflow}, 64'b100);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (4) @(negedge clk);
        check("idle a after reset", {62'd0, bus_a.trace_tx, bus_a.busy}, 64'b10);
        fork
            seq_a();
            seq_b();
        join
        check("framing/timeout errors", 64'(frame_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
